// File: rtl/freq_ratio_calc.sv
// Turns the meter's (refCounter, sigCounter) gate pair into an integer frequency in Hz.
// Captures a coherent pair, multiplies by REF_FREQ_HZ, then restoring-divides by refCount.
module freq_ratio_calc #(
    parameter logic [31:0] REF_FREQ_HZ   = 32'd100_000_000,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned MAX_RETRY     = 4
) (
    input  logic        sysClk,
    input  logic        sysRst,
    input  logic [63:0] refCounter,
    input  logic [63:0] sigCounter,
    output logic [63:0] freqHz,
    output logic        freqValid,
    output logic        busy,
    output logic        divZero,
    output logic        sampleFail,
    output logic        saturated
);

    localparam int unsigned CNT_W   = 64;
    localparam int unsigned NUM_W   = 96;
    localparam int unsigned BIT_W   = 7;
    localparam int unsigned SET_W   = 8;
    localparam int unsigned RETRY_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMP1  = 3'd2,
        S_SAMP2  = 3'd3,
        S_MUL    = 3'd4,
        S_DIV    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_lastRef;
    logic [CNT_W-1:0]   r_refCap;
    logic [CNT_W-1:0]   r_sigCap;
    logic [CNT_W-1:0]   r_s1;
    logic [SET_W-1:0]   r_settle;
    logic [RETRY_W-1:0] r_retry;
    logic [NUM_W-1:0]   r_num;
    logic [NUM_W-1:0]   r_quot;
    logic [CNT_W-1:0]   r_rem;
    logic [BIT_W-1:0]   r_bit;
    logic [CNT_W-1:0]   r_freqHz;
    logic               r_freqValid;
    logic               r_divZero;
    logic               r_sampleFail;
    logic               r_saturated;

    // One restoring-division step: shift in the next numerator bit, trial-subtract the divisor.
    logic [CNT_W:0]     w_trial;
    logic               w_ge;
    logic [CNT_W-1:0]   w_diff;

    assign w_trial = {r_rem, r_num[r_bit]};
    assign w_ge    = (w_trial >= {1'b0, r_refCap});
    assign w_diff  = CNT_W'(w_trial - {1'b0, r_refCap});

    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            r_state      <= S_IDLE;
            r_lastRef    <= '0;
            r_refCap     <= '0;
            r_sigCap     <= '0;
            r_s1         <= '0;
            r_settle     <= '0;
            r_retry      <= '0;
            r_num        <= '0;
            r_quot       <= '0;
            r_rem        <= '0;
            r_bit        <= '0;
            r_freqHz     <= '0;
            r_freqValid  <= 1'b0;
            r_divZero    <= 1'b0;
            r_sampleFail <= 1'b0;
            r_saturated  <= 1'b0;
        end else begin
            r_freqValid  <= 1'b0;
            r_sampleFail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (refCounter != r_lastRef) begin
                        r_lastRef <= refCounter;
                        r_refCap  <= refCounter;
                        r_settle  <= SET_W'(SETTLE_CYCLES - 1);
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == '0) r_state <= S_SAMP1;
                    else                r_settle <= r_settle - SET_W'(1);
                end
                S_SAMP1: begin
                    r_s1    <= sigCounter;
                    r_state <= S_SAMP2;
                end
                // Two equal back-to-back samples are the only coherence guarantee for sigCounter.
                S_SAMP2: begin
                    if (sigCounter == r_s1) begin
                        r_sigCap <= r_s1;
                        r_retry  <= '0;
                        if (r_refCap == '0) begin
                            r_divZero <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state   <= S_MUL;
                        end
                    end else if (r_retry == RETRY_W'(MAX_RETRY - 1)) begin
                        r_sampleFail <= 1'b1;
                        r_retry      <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_retry <= r_retry + RETRY_W'(1);
                        r_state <= S_SAMP1;
                    end
                end
                S_MUL: begin
                    r_num   <= NUM_W'(r_sigCap) * NUM_W'(REF_FREQ_HZ);
                    r_rem   <= '0;
                    r_bit   <= BIT_W'(NUM_W - 1);
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    r_rem  <= w_ge ? w_diff : w_trial[CNT_W-1:0];
                    r_quot <= {r_quot[NUM_W-2:0], w_ge};
                    if (r_bit == '0) r_state <= S_DONE;
                    else             r_bit   <= r_bit - BIT_W'(1);
                end
                S_DONE: begin
                    if (r_quot[NUM_W-1:CNT_W] != '0) begin
                        r_freqHz    <= '1;
                        r_saturated <= 1'b1;
                    end else begin
                        r_freqHz    <= r_quot[CNT_W-1:0];
                        r_saturated <= 1'b0;
                    end
                    r_freqValid <= 1'b1;
                    r_divZero   <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign freqHz     = r_freqHz;
    assign freqValid  = r_freqValid;
    assign busy       = (r_state != S_IDLE);
    assign divZero    = r_divZero;
    assign sampleFail = r_sampleFail;
    assign saturated  = r_saturated;

endmodule

// File: tb/tb_freq_ratio_calc.sv
// Bench for freq_ratio_calc: directed scenarios plus randomized count pairs against an
// arithmetic reference (sig * REF_HZ / ref, truncated and clamped to 64 bits).
module tb_freq_ratio_calc;

    localparam logic [31:0] REF_HZ  = 32'd100_000_000;
    localparam int          SETTLE  = 8;
    localparam int          RETRIES = 4;
    localparam int          LAT     = SETTLE + 101;
    localparam int          BOUND   = 400;

    logic        sysClk = 1'b0;
    logic        sysRst;
    logic [63:0] refCounter;
    logic [63:0] sigCounter;
    logic [63:0] freqHz;
    logic        freqValid, busy, divZero, sampleFail, saturated;

    int n_vec = 0;
    int n_err = 0;

    freq_ratio_calc #(
        .REF_FREQ_HZ  (REF_HZ),
        .SETTLE_CYCLES(SETTLE),
        .MAX_RETRY    (RETRIES)
    ) dut (
        .sysClk    (sysClk),
        .sysRst    (sysRst),
        .refCounter(refCounter),
        .sigCounter(sigCounter),
        .freqHz    (freqHz),
        .freqValid (freqValid),
        .busy      (busy),
        .divZero   (divZero),
        .sampleFail(sampleFail),
        .saturated (saturated)
    );

    always #5 sysClk = ~sysClk;

    // Reference: full-precision product and quotient, clamp if it does not fit in 64 bits.
    function automatic logic [63:0] model_freq(input logic [63:0] s, input logic [63:0] r,
                                               output bit sat);
        logic [127:0] q;
        q   = (128'(s) * 128'(REF_HZ)) / 128'(r);
        sat = (q[127:64] != 64'd0);
        return sat ? 64'hFFFF_FFFF_FFFF_FFFF : q[63:0];
    endfunction

    // Stimulus helper: clock until the block is idle again, logging pulses and their cycle.
    task automatic run_capture(input bit toggle, output int cyc, output int n_valid,
                               output int n_fail, output int first_pulse);
        cyc = 0; n_valid = 0; n_fail = 0; first_pulse = -1;
        do begin
            @(negedge sysClk);
            cyc++;
            if (freqValid)  begin n_valid++; if (first_pulse < 0) first_pulse = cyc; end
            if (sampleFail) begin n_fail++;  if (first_pulse < 0) first_pulse = cyc; end
            if (toggle) sigCounter = ~sigCounter;
        end while (busy && cyc < BOUND);
    endtask

    task automatic test_reset();
        sysRst = 1'b1; refCounter = '0; sigCounter = '0;
        repeat (3) @(negedge sysClk);
        n_vec++;
        if ({freqHz, freqValid, busy, divZero, sampleFail, saturated} !== 69'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got freqHz=%h fv=%b busy=%b dz=%b sf=%b sat=%b, want all 0",
                     freqHz, freqValid, busy, divZero, sampleFail, saturated);
        end
        sysRst = 1'b0;
        repeat (2) @(negedge sysClk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle: busy=%b want 0 with refCounter=0", busy);
        end
    endtask

    task automatic test_basic();
        int cyc, nv, nf, fp;
        logic [63:0] ref_v [3] = '{64'd100_000_000, 64'd99_999_999, 64'd50_000_000};
        logic [63:0] sig_v [3] = '{64'd1000, 64'd12_345_678, 64'd12_345_678};
        logic [63:0] exp_v [3] = '{64'd1000, 64'd12_345_678, 64'd24_691_356};
        for (int i = 0; i < 3; i++) begin
            refCounter = ref_v[i]; sigCounter = sig_v[i];
            run_capture(1'b0, cyc, nv, nf, fp);
            n_vec++;
            if (fp !== LAT || nv !== 1 || nf !== 0) begin
                n_err++;
                $display("FAIL basic_latency[%0d]: pulse at %0d (valid=%0d fail=%0d), want %0d (1,0)",
                         i, fp, nv, nf, LAT);
            end
            n_vec++;
            if (freqHz !== exp_v[i] || saturated !== 1'b0 || divZero !== 1'b0) begin
                n_err++;
                $display("FAIL basic_value[%0d]: freqHz=%0d sat=%b dz=%b, want %0d 0 0",
                         i, freqHz, saturated, divZero, exp_v[i]);
            end
            @(negedge sysClk);
            n_vec++;
            if (busy !== 1'b0 || freqValid !== 1'b0) begin
                n_err++;
                $display("FAIL basic_after[%0d]: busy=%b freqValid=%b, want 0 0", i, busy, freqValid);
            end
        end
    endtask

    task automatic test_divzero();
        int cyc, nv, nf, fp;
        refCounter = 64'd100_000; sigCounter = 64'd1;
        run_capture(1'b0, cyc, nv, nf, fp);
        n_vec++;
        if (freqHz !== 64'd1000 || nv !== 1) begin
            n_err++; $display("FAIL dz_prior: freqHz=%0d valid=%0d, want 1000 1", freqHz, nv);
        end
        refCounter = 64'd0;
        run_capture(1'b0, cyc, nv, nf, fp);
        n_vec++;
        if (divZero !== 1'b1 || nv !== 0 || nf !== 0 || freqHz !== 64'd1000 || cyc !== SETTLE + 3) begin
            n_err++;
            $display("FAIL dz_set: dz=%b valid=%0d fail=%0d freqHz=%0d idle_at=%0d, want 1 0 0 1000 %0d",
                     divZero, nv, nf, freqHz, cyc, SETTLE + 3);
        end
        repeat (5) @(negedge sysClk);
        n_vec++;
        if (divZero !== 1'b1) begin
            n_err++; $display("FAIL dz_sticky: dz=%b want 1", divZero);
        end
        refCounter = 64'd50_000_000; sigCounter = 64'd7;
        run_capture(1'b0, cyc, nv, nf, fp);
        n_vec++;
        if (divZero !== 1'b0 || freqHz !== 64'd14 || nv !== 1) begin
            n_err++; $display("FAIL dz_clear: dz=%b freqHz=%0d valid=%0d, want 0 14 1", divZero, freqHz, nv);
        end
    endtask

    task automatic test_sample_fail();
        int cyc, nv, nf, fp;
        logic [63:0] prev;
        prev = freqHz;
        refCounter = 64'd123_456; sigCounter = 64'h5555_5555_5555_5555;
        run_capture(1'b1, cyc, nv, nf, fp);
        n_vec++;
        // IDLE + SETTLE cycles + MAX_RETRY sample pairs
        if (nf !== 1 || nv !== 0 || fp !== 1 + SETTLE + 2 * RETRIES) begin
            n_err++;
            $display("FAIL sf_pulse: fail=%0d valid=%0d at=%0d, want 1 0 %0d", nf, nv, fp, 1 + SETTLE + 2 * RETRIES);
        end
        n_vec++;
        if (freqHz !== prev || busy !== 1'b0) begin
            n_err++; $display("FAIL sf_hold: freqHz=%0d busy=%b, want %0d 0", freqHz, busy, prev);
        end
        sigCounter = 64'd3;
    endtask

    task automatic test_saturate();
        int cyc, nv, nf, fp;
        refCounter = 64'd1; sigCounter = 64'hFFFF_FFFF_FFFF_FFFF;
        run_capture(1'b0, cyc, nv, nf, fp);
        n_vec++;
        if (freqHz !== 64'hFFFF_FFFF_FFFF_FFFF || saturated !== 1'b1 || nv !== 1 || fp !== LAT) begin
            n_err++;
            $display("FAIL saturate: freqHz=%h sat=%b valid=%0d at=%0d, want all-ones 1 1 %0d",
                     freqHz, saturated, nv, fp, LAT);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, nv, nf, fp;
        refCounter = 64'd777; sigCounter = 64'd5;
        repeat (1 + SETTLE + 2 + 1 + 40) @(negedge sysClk);
        sysRst = 1'b1;
        #1;
        n_vec++;
        if ({freqHz, freqValid, busy, divZero, sampleFail, saturated} !== 69'd0) begin
            n_err++;
            $display("FAIL reset_mid: freqHz=%h fv=%b busy=%b dz=%b sf=%b sat=%b, want all 0",
                     freqHz, freqValid, busy, divZero, sampleFail, saturated);
        end
        refCounter = 64'd200; sigCounter = 64'd2;
        @(negedge sysClk);
        sysRst = 1'b0;
        run_capture(1'b0, cyc, nv, nf, fp);
        n_vec++;
        if (freqHz !== 64'd1_000_000 || nv !== 1 || fp !== LAT) begin
            n_err++;
            $display("FAIL reset_restart: freqHz=%0d valid=%0d at=%0d, want 1000000 1 %0d", freqHz, nv, fp, LAT);
        end
    endtask

    task automatic test_random();
        int cyc, nv, nf, fp;
        bit sat;
        logic [63:0] r, s, exp;
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 2))
                0:       begin r = 64'($urandom) + 64'd1; s = 64'($urandom); end
                1:       begin r = {32'($urandom), 32'($urandom)} | 64'd1; s = {32'($urandom), 32'($urandom)}; end
                default: begin r = 64'($urandom_range(1, 1000)); s = {32'($urandom), 32'($urandom)}; end
            endcase
            if (r == refCounter) r = r + 64'd1;
            exp = model_freq(s, r, sat);
            refCounter = r; sigCounter = s;
            run_capture(1'b0, cyc, nv, nf, fp);
            n_vec++;
            if (freqHz !== exp || saturated !== sat || nv !== 1 || fp !== LAT) begin
                n_err++;
                $display("FAIL random[%0d]: ref=%h sig=%h got %h sat=%b valid=%0d at=%0d, want %h sat=%b at=%0d",
                         i, r, s, freqHz, saturated, nv, fp, exp, sat, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divzero();
        test_sample_fail();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
